// File: rtl/cell_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cell_tb_pkg
// Purpose  : Shared types and golden truth tables for the standard-cell
//            vector sequencers (sweep FSM states, per-cell golden outputs).
// Revision : 1.0  initial release
// ============================================================================
package cell_tb_pkg;

  // Upper bound on the programmable settle time; sizes the settle counter.
  localparam int SETTLE_MAX = 15;
  localparam int SETTLE_W   = 4;

  // Golden outputs, bit i = expected ZN for input vector i.
  // 6-input cells use the order {A1,A2,B1,B2,C1,C2}, MSB = A1.
  localparam logic [63:0] TRUTH_AOI222 = 64'h0000_0777_0777_0777;
  localparam logic [63:0] TRUTH_AO222  = 64'hFFFF_F888_F888_F888;
  localparam logic [63:0] TRUTH_OAI222 = 64'h111F_111F_111F_FFFF;
  localparam logic [63:0] TRUTH_OA222  = 64'hEEE0_EEE0_EEE0_0000;
  // 5-input cell, order {A1,A2,B1,B2,C}, MSB = A1.
  localparam logic [31:0] TRUTH_AOI221 = 32'h0015_1515;

  // Sweep FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage : cell_tb_pkg
`default_nettype wire

// File: rtl/cell_vector_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : cell_vector_sequencer_if
// Purpose  : Bundle between the vector sequencer (master) and the cell
//            environment (slave): start/resp in, stimulus and results out.
// Revision : 1.0  initial release
// ============================================================================
interface cell_vector_sequencer_if #(
  parameter int N_IN = 6
) ();

  logic            start;
  logic            resp;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            first_err_valid;
  logic [N_IN-1:0] first_err_idx;

  // Sequencer side.
  modport master (
    input  start, resp,
    output stim, busy, done, pass, err_count, first_err_valid, first_err_idx
  );

  // Environment side: drives start and the cell output, observes results.
  modport slave (
    output start, resp,
    input  stim, busy, done, pass, err_count, first_err_valid, first_err_idx
  );

endinterface : cell_vector_sequencer_if
`default_nettype wire

// File: rtl/cell_vector_sequencer_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : settle_timer
// Purpose  : Loadable up-counter; load forces the count to 1, enable adds 1,
//            expire is high while the count equals LIMIT.
// Revision : 1.0  initial release
// ============================================================================
module settle_timer #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] LIMIT = 4'd2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_load,
  input  wire logic i_en,
  output logic      o_expire
);

  logic [WIDTH-1:0] r_count;

  // Count register: load has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= WIDTH'(1);
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_expire = (r_count == LIMIT);

endmodule : settle_timer
`default_nettype wire

// File: rtl/cell_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cell_vector_sequencer
// Purpose  : Exhaustive clocked check of a combinational cell. Sweeps every
//            input vector in binary order, holds each for SETTLE cycles,
//            samples the cell output in a single CHECK cycle and compares it
//            with the golden TRUTH table. Reports error count, first failing
//            vector and pass/done.
// Revision : 1.0  initial release
// ============================================================================
module cell_vector_sequencer
  import cell_tb_pkg::*;
#(
  parameter int                 N_IN   = 6,
  parameter int                 SETTLE = 2,           // legal 1..SETTLE_MAX
  parameter logic [2**N_IN-1:0] TRUTH  = TRUTH_AOI222
) (
  input wire logic                 clk,
  input wire logic                 rst,
  cell_vector_sequencer_if.master  bus
);

  // Last vector index, held one bit wider so the final compare needs no wrap.
  localparam logic [N_IN:0]     c_LAST   = {1'b0, {N_IN{1'b1}}};
  localparam logic [SETTLE_W-1:0] c_SETTLE = SETTLE_W'(SETTLE);

  state_t          r_state;
  state_t          w_state_next;

  logic [N_IN:0]   r_idx;
  logic [N_IN:0]   r_err;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            r_fev;
  logic [N_IN-1:0] r_fei;

  logic            w_start_ok;
  logic            w_last;
  logic            w_expect;
  logic            w_mismatch;
  logic [N_IN:0]   w_err_next;
  logic            w_tmr_load;
  logic            w_tmr_en;
  logic            w_tmr_expire;

  settle_timer #(
    .WIDTH (SETTLE_W),
    .LIMIT (c_SETTLE)
  ) u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_tmr_load),
    .i_en     (w_tmr_en),
    .o_expire (w_tmr_expire)
  );

  // start only counts when no sweep is running
  assign w_start_ok = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last     = (r_idx == c_LAST);
  assign w_expect   = TRUTH[r_idx[N_IN-1:0]];
  // Case inequality so an X/Z cell output is flagged in simulation.
  assign w_mismatch = (r_state == ST_CHECK) && (bus.resp !== w_expect);
  assign w_err_next = r_err + {{N_IN{1'b0}}, w_mismatch};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and settle-timer control.
  always_comb begin
    w_state_next = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_en     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_ok) begin
          w_state_next = ST_SETTLE;
          w_tmr_load   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (w_tmr_expire) begin
          w_state_next = ST_CHECK;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_SETTLE;
          w_tmr_load   = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Vector index, result counters and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_err  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_fev  <= 1'b0;
      r_fei  <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_idx  <= '0;
            r_err  <= '0;
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_fev  <= 1'b0;
            r_fei  <= '0;
          end
        end
        ST_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_fev) begin
            r_fev <= 1'b1;
            r_fei <= r_idx[N_IN-1:0];
          end
          if (w_last) begin
            // Final vector: stim stays on the all-ones vector.
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (w_err_next == '0);
          end else begin
            // Advancing here keeps stim stable through the CHECK cycle itself.
            r_idx <= r_idx + {{N_IN{1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.stim            = r_idx[N_IN-1:0];
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.err_count       = r_err;
  assign bus.first_err_valid = r_fev;
  assign bus.first_err_idx   = r_fei;

endmodule : cell_vector_sequencer
`default_nettype wire

// File: tb/tb_cell_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_vector_sequencer
// Purpose  : Directed self-checking bench for cell_vector_sequencer with a
//            behavioural AOI222 cell on resp and injectable faults.
// Revision : 1.0  initial release
// ============================================================================
module tb_cell_vector_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   mode = 0;       // 0 good cell, 1 stuck-at-0, 2 inverted at vector 42
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  cell_vector_sequencer_if #(.N_IN(6)) if0 ();
  cell_vector_sequencer_if #(.N_IN(6)) if1 ();
  cell_vector_sequencer_if #(.N_IN(6)) if2 ();

  cell_vector_sequencer #(.N_IN(6), .SETTLE(2))  u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  cell_vector_sequencer #(.N_IN(6), .SETTLE(1))  u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  cell_vector_sequencer #(.N_IN(6), .SETTLE(15)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Behavioural cell: ZN = !((A1&A2)|(B1&B2)|(C1&C2)), plus fault injection.
  function automatic logic cell_model(input logic [5:0] s, input int m);
    logic zn;
    zn = ~((s[5] & s[4]) | (s[3] & s[2]) | (s[1] & s[0]));
    if (m == 1) return 1'b0;
    if (m == 2 && s == 6'd42) return ~zn;
    return zn;
  endfunction

  always_comb if0.resp = cell_model(if0.stim, mode);
  always_comb if1.resp = cell_model(if1.stim, mode);
  always_comb if2.resp = cell_model(if2.stim, mode);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_start(input int inst, input logic v);
    case (inst)
      0:       if0.start = v;
      1:       if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  function automatic logic [5:0] stim_of(input int inst);
    case (inst)
      0:       return if0.stim;
      1:       return if1.stim;
      default: return if2.stim;
    endcase
  endfunction

  function automatic logic done_of(input int inst);
    case (inst)
      0:       return if0.done;
      1:       return if1.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic pass_of(input int inst);
    case (inst)
      0:       return if0.pass;
      1:       return if1.pass;
      default: return if2.pass;
    endcase
  endfunction

  // Pulse start, then count edges until done. Every cycle stim must equal
  // cycles/(settle+1) (capped at 63). Optionally re-pulse start at a vector.
  task automatic run_sweep(input int inst, input int settle, input int pulse_at,
                           output int cycles, output int bad);
    int  exp_stim;
    bit  pulsed;
    pulsed = 1'b0;
    @(negedge clk); set_start(inst, 1'b1);
    @(negedge clk); set_start(inst, 1'b0);
    cycles = 0;
    bad    = (stim_of(inst) != 6'd0) ? 1 : 0;
    while (!done_of(inst) && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      exp_stim = cycles / (settle + 1);
      if (exp_stim > 63) exp_stim = 63;
      if (int'(stim_of(inst)) != exp_stim) bad++;
      if (pulse_at >= 0 && !pulsed && int'(stim_of(inst)) == pulse_at) begin
        set_start(inst, 1'b1);
        pulsed = 1'b1;
      end else begin
        set_start(inst, 1'b0);
      end
    end
    set_start(inst, 1'b0);
  endtask

  initial begin
    int cyc;
    int bad;
    int guard;
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_stim", 32'(if0.stim), 0);
    check("rst_flags", {if0.busy, if0.done, if0.pass, if0.first_err_valid}, 0);
    check("rst_err", 32'(if0.err_count), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_flags", {if0.busy, if0.done, if0.pass, if0.stim}, 0);

    // Golden sweep, SETTLE=2.
    mode = 0;
    run_sweep(0, 2, -1, cyc, bad);
    check("gold_cycles", cyc, 192);
    check("gold_stim_steps", bad, 0);
    check("gold_err", 32'(if0.err_count), 0);
    check("gold_pass", 32'(if0.pass), 1);
    check("gold_fev", 32'(if0.first_err_valid), 0);
    check("gold_busy", 32'(if0.busy), 0);
    check("gold_stim_last", 32'(if0.stim), 63);
    repeat (4) @(negedge clk);
    check("gold_hold", {if0.done, if0.pass, if0.stim}, {1'b1, 1'b1, 6'd63});

    // Stuck-at-0 cell output, restarted from DONE.
    mode = 1;
    run_sweep(0, 2, -1, cyc, bad);
    check("sa0_cycles", cyc, 192);
    check("sa0_err", 32'(if0.err_count), 27);
    check("sa0_fei", 32'(if0.first_err_idx), 0);
    check("sa0_fev", 32'(if0.first_err_valid), 1);
    check("sa0_pass", 32'(if0.pass), 0);

    // Single fault at vector 42.
    mode = 2;
    run_sweep(0, 2, -1, cyc, bad);
    check("f42_err", 32'(if0.err_count), 1);
    check("f42_fei", 32'(if0.first_err_idx), 42);
    check("f42_fev", 32'(if0.first_err_valid), 1);
    check("f42_pass", 32'(if0.pass), 0);

    // Good cell with start re-pulsed mid-sweep: ignored, counters cleared.
    mode = 0;
    run_sweep(0, 2, 20, cyc, bad);
    check("repulse_cycles", cyc, 192);
    check("repulse_stim_steps", bad, 0);
    check("repulse_err", 32'(if0.err_count), 0);
    check("repulse_pass", 32'(if0.pass), 1);
    check("repulse_fev", 32'(if0.first_err_valid), 0);

    // Asynchronous reset in the middle of a failing sweep.
    mode = 1;
    @(negedge clk); if0.start = 1'b1;
    @(negedge clk); if0.start = 1'b0;
    guard = 0;
    while (if0.stim != 6'd20 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("mid_stim", 32'(if0.stim), 20);
    check("mid_err", 32'(if0.err_count), 12);
    check("mid_busy", 32'(if0.busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_stim", 32'(if0.stim), 0);
    check("arst_flags", {if0.busy, if0.done, if0.pass, if0.first_err_valid}, 0);
    check("arst_err", 32'(if0.err_count), 0);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_idle", {if0.busy, if0.done, if0.stim, if0.err_count}, 0);

    // SETTLE=1 and SETTLE=15 builds.
    mode = 0;
    run_sweep(1, 1, -1, cyc, bad);
    check("s1_cycles", cyc, 128);
    check("s1_stim_steps", bad, 0);
    check("s1_pass", 32'(pass_of(1)), 1);
    run_sweep(2, 15, -1, cyc, bad);
    check("s15_cycles", cyc, 1024);
    check("s15_stim_steps", bad, 0);
    check("s15_pass", 32'(pass_of(2)), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_cell_vector_sequencer
`default_nettype wire
